rpsc_startup_sequencer: RTL and testbench
=========================================

// Module: rpsc_startup_sequencer
// PURPOSE
//  Sequences RPSC power-up and shut-down: fan start, CA supply permission and CA settle, then RUN.
//  Sits above the card-1 interlock logic, which it drives and monitors.
//  Any interlock loss or step timeout trips to a latched FAULT with a code; exit needs an operator ack.
//  Fan is kept running for a cool-down period after every stop or fault.
// PARAMETERS
//  TW           22          width of the timeout/cool-down down-counter
//  FAN_TIMEOUT  22'd781250  max cycles from fan_on_cmd to fan_act (1 s at 1.28 us)
//  CA_TIMEOUT   22'd781250  max cycles from ca_on_perm to ca_ps_act; also max for ca_ok settle
//  SETTLE       8'd200      consecutive cycles ca_ok must be high before RUN
//  FAN_COOL     22'd3125000 fan run-on cycles after CA drop (4 s)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  start_req    in   1  level; operator start request
//  stop_req     in   1  level; operator stop request
//  fault_ack    in   1  level; operator fault acknowledge
//  interlock_ok in   1  high = no status alarm (water, air, DC PS, card position)
//  fan_act      in   1  high = fan running, confirmed
//  ca_ps_act    in   1  high = CA supply active
//  ca_ok        in   1  high = CA voltage/current within limits
//  fan_on_cmd   out  1  fan run command
//  ca_on_perm   out  1  CA supply permission
//  ready        out  1  high only in RUN
//  fault        out  1  high only in FAULT
//  fault_code   out  3  latched cause; 0 while not in FAULT
//  state_o      out  3  encoded state, for debug
// BEHAVIOUR
//  Reset: state IDLE, counters 0, all outputs 0, fault_code 0. Applies asynchronously, even mid-sequence.
//  Encoding: IDLE=0 FAN_WAIT=1 CA_WAIT=2 CA_SETTLE=3 RUN=4 STOPPING=5 FAULT=6.
//  Outputs are a registered-state decode. They change in the cycle after the transition edge.
//    fan_on_cmd=1 in states 1-5, and in FAULT while cool-down is not done.
//    ca_on_perm=1 in states 2-4.
//  Timer tmr: loaded on state entry, decrements once per cycle, saturates at 0.
//    "timeout" means tmr==0 while the wait condition is still false.
//  Transition priority in states 1-4, highest first: interlock loss > timeout/loss > stop_req > advance.
//  IDLE
//    start_req=1 and interlock_ok=1 -> FAN_WAIT, tmr<=FAN_TIMEOUT.
//    start_req=1 with interlock_ok=0 -> stays IDLE; no fault raised.
//  FAN_WAIT
//    !interlock_ok -> FAULT, code 1.
//    timeout -> FAULT, code 2.
//    stop_req -> STOPPING.
//    fan_act -> CA_WAIT, tmr<=CA_TIMEOUT.
//  CA_WAIT
//    !interlock_ok -> FAULT, code 1.
//    !fan_act -> FAULT, code 5.
//    timeout -> FAULT, code 3.
//    stop_req -> STOPPING.
//    ca_ps_act -> CA_SETTLE, tmr<=CA_TIMEOUT, settle count scnt<=0.
//  CA_SETTLE
//    scnt increments while ca_ok=1 and clears to 0 when ca_ok=0.
//    Fault checks as in CA_WAIT. !ca_ps_act -> FAULT, code 6.
//    timeout -> FAULT, code 4.
//    stop_req -> STOPPING.
//    scnt==SETTLE-1 with ca_ok=1 -> RUN, i.e. SETTLE consecutive ca_ok cycles.
//  RUN
//    !interlock_ok -> FAULT, code 1.
//    !fan_act -> FAULT, code 5.
//    !ca_ps_act or !ca_ok -> FAULT, code 6.
//    stop_req -> STOPPING.
//  Every entry to STOPPING or FAULT loads tmr<=FAN_COOL.
//  STOPPING
//    ca_on_perm=0 immediately; fan held on.
//    tmr==0 -> IDLE. Interlock loss here is ignored; shutdown is already in progress.
//  FAULT
//    fault=1, fault_code held.
//    Leaves only when tmr==0 and fault_ack=1 and start_req=0 -> IDLE, and fault_code clears to 0.
//    fault_ack while cool-down is still running is ignored.
//  start_req held high in IDLE restarts at once. Levels are not edge-detected.
//  Inputs are pre-synchronised upstream; no metastability handling in this block.
// TESTING
//  Params TW=8, FAN_TIMEOUT=8, CA_TIMEOUT=8, SETTLE=4, FAN_COOL=5.
//  1 Happy path: start_req=1; fan_act 3 cycles after fan_on_cmd; ca_ps_act 2 cycles after ca_on_perm; ca_ok=1
//    -> states 1,2,3,4 in order; ready=1 after 4 ca_ok cycles in CA_SETTLE.
//  2 Fan timeout: start_req=1, fan_act=0 -> FAULT, code 2, after 9 cycles in FAN_WAIT.
//    fan_on_cmd falls 5 cycles later.
//    fault_ack before cool-down is done is ignored; ack after -> IDLE, code 0.
//  3 Settle glitch: ca_ok pulses 1,1,0,1,1,1,1 -> scnt restarts; RUN entered after the final 4 consecutive ones.
//    Without 4 consecutive ones within 9 cycles -> FAULT, code 4.
//  4 Interlock during RUN: interlock_ok=0 with stop_req=1 in the same cycle -> FAULT, code 1 (priority).
//    ca_on_perm=0 next cycle.
//  5 Normal stop: stop_req in RUN -> STOPPING; ca_on_perm=0, fan_on_cmd=1 for 5 cycles, then IDLE with all outputs 0.
//  6 Async reset asserted mid CA_SETTLE, between clock edges -> all outputs 0 immediately, state_o=0.

Source files
------------

// File: rtl/rpsc_startup_sequencer.sv
// RPSC power-up/shut-down sequencer: fan start, CA permission, CA settle, RUN.
// Any interlock loss or step timeout trips to a latched FAULT that needs an operator ack.
module rpsc_startup_sequencer #(
  parameter int          TW          = 22,
  parameter logic [TW-1:0] FAN_TIMEOUT = 22'd781250,
  parameter logic [TW-1:0] CA_TIMEOUT  = 22'd781250,
  parameter logic [7:0]  SETTLE      = 8'd200,
  parameter logic [TW-1:0] FAN_COOL    = 22'd3125000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_ack,
  input  logic       interlock_ok,
  input  logic       fan_act,
  input  logic       ca_ps_act,
  input  logic       ca_ok,
  output logic       fan_on_cmd,
  output logic       ca_on_perm,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FAN_WAIT  = 3'd1,
    S_CA_WAIT   = 3'd2,
    S_CA_SETTLE = 3'd3,
    S_RUN       = 3'd4,
    S_STOPPING  = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [7:0]    scnt;
  logic [2:0]    code;
  logic          tmr_zero;
  logic          settle_done;

  assign tmr_zero    = (tmr == '0);
  assign settle_done = ca_ok && (scnt == SETTLE - 8'd1);

  // Later assignments in the case override the default timer decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      tmr   <= '0;
      scnt  <= '0;
      code  <= '0;
    end else begin
      if (!tmr_zero) tmr <= tmr - 1'b1;
      case (state)
        S_IDLE: begin
          if (start_req && interlock_ok) begin
            state <= S_FAN_WAIT;
            tmr   <= FAN_TIMEOUT;
          end
        end
        S_FAN_WAIT: begin
          if (!interlock_ok) begin
            state <= S_FAULT; code <= 3'd1; tmr <= FAN_COOL;
          end else if (tmr_zero && !fan_act) begin
            state <= S_FAULT; code <= 3'd2; tmr <= FAN_COOL;
          end else if (stop_req) begin
            state <= S_STOPPING; tmr <= FAN_COOL;
          end else if (fan_act) begin
            state <= S_CA_WAIT; tmr <= CA_TIMEOUT;
          end
        end
        S_CA_WAIT: begin
          if (!interlock_ok) begin
            state <= S_FAULT; code <= 3'd1; tmr <= FAN_COOL;
          end else if (!fan_act) begin
            state <= S_FAULT; code <= 3'd5; tmr <= FAN_COOL;
          end else if (tmr_zero && !ca_ps_act) begin
            state <= S_FAULT; code <= 3'd3; tmr <= FAN_COOL;
          end else if (stop_req) begin
            state <= S_STOPPING; tmr <= FAN_COOL;
          end else if (ca_ps_act) begin
            state <= S_CA_SETTLE; tmr <= CA_TIMEOUT; scnt <= '0;
          end
        end
        S_CA_SETTLE: begin
          scnt <= ca_ok ? scnt + 8'd1 : 8'd0;
          if (!interlock_ok) begin
            state <= S_FAULT; code <= 3'd1; tmr <= FAN_COOL;
          end else if (!fan_act) begin
            state <= S_FAULT; code <= 3'd5; tmr <= FAN_COOL;
          end else if (!ca_ps_act) begin
            state <= S_FAULT; code <= 3'd6; tmr <= FAN_COOL;
          end else if (tmr_zero && !settle_done) begin
            state <= S_FAULT; code <= 3'd4; tmr <= FAN_COOL;
          end else if (stop_req) begin
            state <= S_STOPPING; tmr <= FAN_COOL;
          end else if (settle_done) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!interlock_ok) begin
            state <= S_FAULT; code <= 3'd1; tmr <= FAN_COOL;
          end else if (!fan_act) begin
            state <= S_FAULT; code <= 3'd5; tmr <= FAN_COOL;
          end else if (!ca_ps_act || !ca_ok) begin
            state <= S_FAULT; code <= 3'd6; tmr <= FAN_COOL;
          end else if (stop_req) begin
            state <= S_STOPPING; tmr <= FAN_COOL;
          end
        end
        S_STOPPING: begin
          // Shutdown is already under way, so interlock loss is not a fault here.
          if (tmr_zero) state <= S_IDLE;
        end
        S_FAULT: begin
          if (tmr_zero && fault_ack && !start_req) begin
            state <= S_IDLE;
            code  <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          code  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    fan_on_cmd = 1'b0;
    ca_on_perm = 1'b0;
    ready      = 1'b0;
    fault      = 1'b0;
    fault_code = 3'd0;
    case (state)
      S_FAN_WAIT, S_STOPPING: fan_on_cmd = 1'b1;
      S_CA_WAIT, S_CA_SETTLE: begin
        fan_on_cmd = 1'b1;
        ca_on_perm = 1'b1;
      end
      S_RUN: begin
        fan_on_cmd = 1'b1;
        ca_on_perm = 1'b1;
        ready      = 1'b1;
      end
      S_FAULT: begin
        fan_on_cmd = !tmr_zero;
        fault      = 1'b1;
        fault_code = code;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_rpsc_startup_sequencer.sv
// Directed bench for rpsc_startup_sequencer with short timeouts so every path fits in a few cycles.
module tb_rpsc_startup_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_req, stop_req, fault_ack, interlock_ok;
  logic       fan_act, ca_ps_act, ca_ok;
  logic       fan_on_cmd, ca_on_perm, ready, fault;
  logic [2:0] fault_code, state_o;

  int total = 0;
  int bad   = 0;

  rpsc_startup_sequencer #(
    .TW(8), .FAN_TIMEOUT(8'd8), .CA_TIMEOUT(8'd8), .SETTLE(8'd4), .FAN_COOL(8'd5)
  ) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req),
    .fault_ack(fault_ack), .interlock_ok(interlock_ok), .fan_act(fan_act),
    .ca_ps_act(ca_ps_act), .ca_ok(ca_ok), .fan_on_cmd(fan_on_cmd),
    .ca_on_perm(ca_on_perm), .ready(ready), .fault(fault),
    .fault_code(fault_code), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic fan,
                          input logic perm, input logic rdy, input logic flt, input logic [2:0] code);
    chk({tag, ".state"}, {5'd0, state_o}, {5'd0, st});
    chk({tag, ".fan"}, {7'd0, fan_on_cmd}, {7'd0, fan});
    chk({tag, ".perm"}, {7'd0, ca_on_perm}, {7'd0, perm});
    chk({tag, ".ready"}, {7'd0, ready}, {7'd0, rdy});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, flt});
    chk({tag, ".code"}, {5'd0, fault_code}, {5'd0, code});
  endtask

  // Bounded wait for a state; an expired budget shows up as a failed check.
  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    for (int i = 0; i < budget && state_o !== st; i++) tick();
    chk(tag, {5'd0, state_o}, {5'd0, st});
  endtask

  task automatic clear_inputs();
    start_req = 0; stop_req = 0; fault_ack = 0;
    fan_act = 0; ca_ps_act = 0; ca_ok = 0;
    interlock_ok = 1;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    tick(); tick();
    chk_outs("reset", 3'd0, 0, 0, 0, 0, 3'd0);
    reset = 0;
    tick();
    chk_outs("idle_after_reset", 3'd0, 0, 0, 0, 0, 3'd0);

    // Start refused while the interlock is not ok; no fault either.
    interlock_ok = 0; start_req = 1;
    tick(); tick();
    chk_outs("start_no_interlock", 3'd0, 0, 0, 0, 0, 3'd0);

    // 1 Happy path
    interlock_ok = 1;
    tick();
    chk_outs("t1_fan_wait", 3'd1, 1, 0, 0, 0, 3'd0);
    start_req = 0;
    tick(); tick();
    chk("t1_still_fan_wait", {5'd0, state_o}, 8'd1);
    fan_act = 1;
    tick();
    chk_outs("t1_ca_wait", 3'd2, 1, 1, 0, 0, 3'd0);
    tick();
    ca_ps_act = 1; ca_ok = 1;
    tick();
    chk_outs("t1_ca_settle", 3'd3, 1, 1, 0, 0, 3'd0);
    tick(); tick(); tick();
    chk_outs("t1_settle_3_ok", 3'd3, 1, 1, 0, 0, 3'd0);
    tick();
    chk_outs("t1_run", 3'd4, 1, 1, 1, 0, 3'd0);

    // 5 Normal stop
    stop_req = 1;
    tick();
    chk_outs("t5_stopping", 3'd5, 1, 0, 0, 0, 3'd0);
    stop_req = 0; interlock_ok = 0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("t5_fan_held", {7'd0, fan_on_cmd}, 8'd1);
    end
    chk("t5_still_stopping", {5'd0, state_o}, 8'd5);
    wait_state("t5_back_idle", 3'd0, 3);
    chk_outs("t5_idle_outs", 3'd0, 0, 0, 0, 0, 3'd0);

    // 2 Fan timeout
    clear_inputs();
    start_req = 1;
    tick();
    chk("t2_fan_wait", {5'd0, state_o}, 8'd1);
    start_req = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_fan_wait_8", {5'd0, state_o}, 8'd1);
    tick();
    chk_outs("t2_fault", 3'd6, 1, 0, 0, 1, 3'd2);
    fault_ack = 1;
    for (int i = 0; i < 4; i++) tick();
    chk_outs("t2_ack_ignored", 3'd6, 1, 0, 0, 1, 3'd2);
    tick();
    chk_outs("t2_cooldown_done", 3'd6, 0, 0, 0, 1, 3'd2);
    tick();
    chk_outs("t2_ack_idle", 3'd0, 0, 0, 0, 0, 3'd0);
    fault_ack = 0;

    // 3 Settle glitch: 1,1,0,1,1,1,1 restarts the count
    start_req = 1; fan_act = 1; ca_ps_act = 1;
    tick(); tick(); tick();
    chk("t3_settle", {5'd0, state_o}, 8'd3);
    start_req = 0;
    ca_ok = 1; tick(); ca_ok = 1; tick(); ca_ok = 0; tick();
    ca_ok = 1; tick(); tick(); tick();
    chk("t3_not_yet_run", {5'd0, state_o}, 8'd3);
    tick();
    chk_outs("t3_run", 3'd4, 1, 1, 1, 0, 3'd0);
    stop_req = 1; tick(); stop_req = 0;
    wait_state("t3_idle", 3'd0, 10);

    // 3b Never 4 consecutive ca_ok cycles -> settle timeout
    start_req = 1; ca_ok = 0;
    tick(); tick(); tick();
    chk("t3b_settle", {5'd0, state_o}, 8'd3);
    start_req = 0;
    for (int i = 0; i < 8; i++) begin
      ca_ok = (i % 4 != 3);
      tick();
    end
    chk("t3b_settle_8", {5'd0, state_o}, 8'd3);
    ca_ok = 1;
    tick();
    chk_outs("t3b_fault", 3'd6, 1, 0, 0, 1, 3'd4);
    ca_ok = 0; fault_ack = 1;
    wait_state("t3b_idle", 3'd0, 10);
    fault_ack = 0;

    // 4 Interlock loss beats stop_req in RUN
    start_req = 1; ca_ok = 1;
    tick(); tick(); tick();
    start_req = 0;
    tick(); tick(); tick(); tick();
    chk("t4_run", {5'd0, state_o}, 8'd4);
    interlock_ok = 0; stop_req = 1;
    tick();
    chk_outs("t4_fault", 3'd6, 1, 0, 0, 1, 3'd1);
    interlock_ok = 1; stop_req = 0; fault_ack = 1;
    wait_state("t4_idle", 3'd0, 10);
    chk("t4_code_clear", {5'd0, fault_code}, 8'd0);
    fault_ack = 0;

    // 6 Async reset in the middle of CA_SETTLE
    start_req = 1; ca_ok = 0;
    tick(); tick(); tick();
    chk("t6_settle", {5'd0, state_o}, 8'd3);
    start_req = 0;
    #2 reset = 1;
    #1 chk_outs("t6_async", 3'd0, 0, 0, 0, 0, 3'd0);
    tick();
    reset = 0;
    tick();
    chk_outs("t6_after_release", 3'd0, 0, 0, 0, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
